ca_grid_engine: RTL and testbench

Parametrised cellular-automaton generation engine for an ROWS×COLS binary grid. It is the successor to the fixed 8×8 toroidal "all four neighbours live" updater, and adds:
- programmable birth/survive rules over the von Neumann neighbour count;
- selectable wrap or zero boundary;
- synchronous (double-buffered) or in-place raster update;
- multi-generation runs with population reporting.

It sits between the host-side grid loader and the display/readout path.

---
 rtl/ca_pkg.sv | 25 ++
 rtl/ca_cell_rule.sv | 14 +
 rtl/ca_grid_engine.sv | 169 ++++++++++++++++
 tb/tb_ca_grid_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared types, constants and wrap-index helpers for the CA grid engine
package ca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        DONE
    } state_t;

    localparam int NBR_MAX = 4;
    localparam int NBR_W   = $clog2(NBR_MAX + 1);

    typedef logic [NBR_MAX:0] rule_mask_t;

    // Explicit edge tests instead of modulo so negative indices never arise.
    function automatic int wrap_dec(input int idx, input int size);
        return (idx == 0) ? size - 1 : idx - 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int size);
        return (idx == size - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ca_cell_rule.sv
// rtl/ca_cell_rule.sv - combinational birth/survive rule for one cell
module ca_cell_rule
    import ca_pkg::*;
(
    input  logic             cur,
    input  logic [NBR_W-1:0] n,
    input  logic [NBR_MAX:0] birth_mask,
    input  logic [NBR_MAX:0] survive_mask,
    output logic             next
);

    assign next = cur ? survive_mask[n] : birth_mask[n];

endmodule

// File: rtl/ca_grid_engine.sv
// rtl/ca_grid_engine.sv - ROWS x COLS cellular-automaton engine, one cell per cycle raster scan
module ca_grid_engine
    import ca_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_en,
    input  logic [$clog2(ROWS)-1:0]         load_row,
    input  logic [COLS-1:0]                 load_data,
    input  logic                            start,
    input  logic [GEN_W-1:0]                gen_count,
    input  logic [NBR_MAX:0]                birth_mask,
    input  logic [NBR_MAX:0]                survive_mask,
    input  logic                            wrap,
    input  logic                            in_place,
    input  logic [$clog2(ROWS)-1:0]         rd_row,
    output logic [COLS-1:0]                 rd_data,
    output logic                            busy,
    output logic                            done,
    output logic [GEN_W-1:0]                gens_done,
    output logic [$clog2(ROWS*COLS+1)-1:0]  pop
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(ROWS * COLS + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t           state;
    logic [COLS-1:0]  grid   [ROWS];
    logic [COLS-1:0]  shadow [ROWS];

    logic [RW-1:0]    row_idx;
    logic [CW-1:0]    col_idx;
    logic [GEN_W-1:0] gen_q;
    rule_mask_t       birth_q;
    rule_mask_t       survive_q;
    logic             wrap_q;
    logic             in_place_q;
    logic [PW-1:0]    acc;

    logic [RW-1:0]    row_n;
    logic [RW-1:0]    row_s;
    logic [CW-1:0]    col_w;
    logic [CW-1:0]    col_e;
    logic             nb_n;
    logic             nb_s;
    logic             nb_w;
    logic             nb_e;
    logic             cur;
    logic             nxt;
    logic [NBR_W-1:0] nbr;

    assign row_n = RW'(wrap_dec(int'(row_idx), ROWS));
    assign row_s = RW'(wrap_inc(int'(row_idx), ROWS));
    assign col_w = CW'(wrap_dec(int'(col_idx), COLS));
    assign col_e = CW'(wrap_inc(int'(col_idx), COLS));

    // With zero boundary, a wrapped index is masked off rather than read.
    assign nb_n = (wrap_q || (row_idx != '0))       && grid[row_n][col_idx];
    assign nb_s = (wrap_q || (row_idx != ROW_LAST)) && grid[row_s][col_idx];
    assign nb_w = (wrap_q || (col_idx != '0))       && grid[row_idx][col_w];
    assign nb_e = (wrap_q || (col_idx != COL_LAST)) && grid[row_idx][col_e];

    assign cur = grid[row_idx][col_idx];
    assign nbr = NBR_W'(nb_n) + NBR_W'(nb_s) + NBR_W'(nb_w) + NBR_W'(nb_e);

    ca_cell_rule u_rule (
        .cur          (cur),
        .n            (nbr),
        .birth_mask   (birth_q),
        .survive_mask (survive_q),
        .next         (nxt)
    );

    assign rd_data = grid[rd_row];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grid       <= '{default: '0};
            shadow     <= '{default: '0};
            row_idx    <= '0;
            col_idx    <= '0;
            gen_q      <= '0;
            birth_q    <= '0;
            survive_q  <= '0;
            wrap_q     <= 1'b0;
            in_place_q <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gens_done  <= '0;
            pop        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        grid[load_row] <= load_data;
                    end
                    if (start) begin
                        if (gen_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            gen_q      <= gen_count;
                            birth_q    <= birth_mask;
                            survive_q  <= survive_mask;
                            wrap_q     <= wrap;
                            in_place_q <= in_place;
                            gens_done  <= '0;
                            row_idx    <= '0;
                            col_idx    <= '0;
                            acc        <= '0;
                            busy       <= 1'b1;
                            state      <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (in_place_q) begin
                        grid[row_idx][col_idx] <= nxt;
                    end else begin
                        shadow[row_idx][col_idx] <= nxt;
                    end
                    acc <= acc + PW'(nxt);
                    if (col_idx == COL_LAST) begin
                        col_idx <= '0;
                        if (row_idx == ROW_LAST) begin
                            row_idx <= '0;
                            state   <= COMMIT;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end else begin
                        col_idx <= col_idx + CW'(1);
                    end
                end
                COMMIT: begin
                    if (!in_place_q) begin
                        grid <= shadow;
                    end
                    pop       <= acc;
                    acc       <= '0;
                    gens_done <= gens_done + GEN_W'(1);
                    if ((gens_done + GEN_W'(1)) < gen_q) begin
                        state <= SCAN;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_grid_engine.sv
// tb/tb_ca_grid_engine.sv - scoreboard bench for ca_grid_engine on an 8x8 grid
module tb_ca_grid_engine;

    localparam int K_RUN  = 0;
    localparam int K_SNAP = 1;

    localparam logic [63:0] SINGLE   = 64'h00000000_08000000;
    localparam logic [63:0] SINGLE_1 = 64'h00000008_14080000;
    localparam logic [63:0] CORNER   = 64'h00000000_00000001;
    localparam logic [63:0] CORNER_W = 64'h01000000_00000182;
    localparam logic [63:0] CORNER_Z = 64'h00000000_00000102;
    localparam logic [63:0] INPLACE  = 64'h143C44CC_54F80000;
    localparam logic [63:0] ONES     = 64'hFFFFFFFF_FFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [2:0]  load_row;
    logic [7:0]  load_data;
    logic        start;
    logic [15:0] gen_count;
    logic [4:0]  birth_mask;
    logic [4:0]  survive_mask;
    logic        wrap;
    logic        in_place;
    logic [2:0]  rd_row;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [15:0] gens_done;
    logic [6:0]  pop;

    typedef struct {
        int          kind;
        logic [63:0] grid;
        int          pop;
        int          gens;
        bit          chk_stats;
        int          exp_cyc;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  snap_req = 1'b0;
    logic  snap_ack = 1'b0;

    ca_grid_engine #(.ROWS(8), .COLS(8), .GEN_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .load_row     (load_row),
        .load_data    (load_data),
        .start        (start),
        .gen_count    (gen_count),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .wrap         (wrap),
        .in_place     (in_place),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .gens_done    (gens_done),
        .pop          (pop)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic read_grid(output logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            g[r*8 +: 8] = rd_data;
        end
    endtask

    initial begin : monitor
        exp_t        it;
        string       nm;
        logic [63:0] g;
        forever begin
            @(negedge clk);
            if (done) begin
                check("busy_with_done", 64'(busy), 64'd0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending run", cyc);
                end else begin
                    it = sb_q.pop_front();
                    nm = name_q.pop_front();
                    if (it.kind != K_RUN) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s_order: got done pulse, expected snapshot request", nm);
                    end
                    check({nm, "_done_cycle"}, 64'(cyc), 64'(it.exp_cyc));
                    read_grid(g);
                    check({nm, "_grid"}, g, it.grid);
                    if (it.chk_stats) begin
                        check({nm, "_pop"}, 64'(pop), 64'(it.pop));
                        check({nm, "_gens_done"}, 64'(gens_done), 64'(it.gens));
                    end
                end
            end else if (snap_req && !snap_ack) begin
                if (sb_q.size() != 0) begin
                    it = sb_q.pop_front();
                    nm = name_q.pop_front();
                    read_grid(g);
                    check({nm, "_grid"}, g, it.grid);
                    check({nm, "_pop"}, 64'(pop), 64'(it.pop));
                    check({nm, "_gens_done"}, 64'(gens_done), 64'(it.gens));
                    check({nm, "_busy"}, 64'(busy), 64'd0);
                    check({nm, "_done"}, 64'(done), 64'd0);
                end
                snap_ack = 1'b1;
            end else if (!snap_req) begin
                snap_ack = 1'b0;
            end
        end
    end

    task automatic load_grid(input logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_row  = 3'(r);
            load_data = g[r*8 +: 8];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic [15:0] g, input logic [4:0] bm,
                       input logic [4:0] sm, input logic wr, input logic ip,
                       input logic [63:0] exp_grid, input int exp_pop, input int exp_gens,
                       input bit stats, input int poke_at);
        exp_t it;
        @(negedge clk);
        gen_count    = g;
        birth_mask   = bm;
        survive_mask = sm;
        wrap         = wr;
        in_place     = ip;
        start        = 1'b1;
        it.kind      = K_RUN;
        it.grid      = exp_grid;
        it.pop       = exp_pop;
        it.gens      = exp_gens;
        it.chk_stats = stats;
        it.exp_cyc   = cyc + 1 + int'(g) * 65;
        sb_q.push_back(it);
        name_q.push_back(name);
        @(negedge clk);
        start = 1'b0;
        if (poke_at > 0) begin
            repeat (poke_at) @(negedge clk);
            start        = 1'b1;
            load_en      = 1'b1;
            load_row     = 3'd0;
            load_data    = 8'h00;
            gen_count    = 16'd1;
            birth_mask   = 5'b00000;
            survive_mask = 5'b11111;
            wrap         = 1'b0;
            in_place     = 1'b0;
            @(negedge clk);
            start   = 1'b0;
            load_en = 1'b0;
        end
        wait_done(int'(g) * 65 + 40, name);
    endtask

    task automatic snapshot(input string name, input logic [63:0] exp_grid);
        exp_t it;
        int   k = 0;
        it.kind      = K_SNAP;
        it.grid      = exp_grid;
        it.pop       = 0;
        it.gens      = 0;
        it.chk_stats = 1'b1;
        it.exp_cyc   = 0;
        sb_q.push_back(it);
        name_q.push_back(name);
        snap_req = 1'b1;
        while (!snap_ack && k < 10) begin
            @(posedge clk);
            k++;
        end
        check({name, "_snap_ack"}, 64'(snap_ack), 64'd1);
        snap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin : stim
        rst_n        = 1'b0;
        load_en      = 1'b0;
        load_row     = 3'd0;
        load_data    = 8'h00;
        start        = 1'b0;
        gen_count    = 16'd0;
        birth_mask   = 5'd0;
        survive_mask = 5'd0;
        wrap         = 1'b0;
        in_place     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        load_grid(64'hA5A5A5A5_A5A5A5A5);
        @(negedge clk);
        rst_n = 1'b0;
        snapshot("reset_loaded", 64'd0);
        rst_n = 1'b1;

        load_grid(SINGLE);
        run("single_sync", 16'd1, 5'b00010, 5'b00000, 1'b0, 1'b0, SINGLE_1, 4, 1, 1'b1, 0);
        load_grid(CORNER);
        run("corner_wrap", 16'd1, 5'b00010, 5'b00000, 1'b1, 1'b0, CORNER_W, 4, 1, 1'b1, 0);
        load_grid(CORNER);
        run("corner_zero", 16'd1, 5'b00010, 5'b00000, 1'b0, 1'b0, CORNER_Z, 2, 1, 1'b1, 0);
        load_grid(SINGLE);
        run("in_place", 16'd1, 5'b00010, 5'b00000, 1'b0, 1'b1, INPLACE, 20, 1, 1'b1, 0);
        load_grid(ONES);
        run("legacy_multi", 16'd3, 5'b10000, 5'b10000, 1'b1, 1'b1, ONES, 64, 3, 1'b1, 50);
        run("gen_zero", 16'd0, 5'b00010, 5'b00000, 1'b0, 1'b0, ONES, 0, 0, 1'b0, 0);

        // Abort a run at edge 30: reset must clear everything and swallow the done pulse.
        load_grid(SINGLE);
        @(negedge clk);
        gen_count    = 16'd1;
        birth_mask   = 5'b00010;
        survive_mask = 5'b00000;
        wrap         = 1'b0;
        in_place     = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", 64'(busy), 64'd0);
        check("mid_reset_done", 64'(done), 64'd0);
        snapshot("mid_reset", 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);

        load_grid(SINGLE);
        run("after_reset", 16'd1, 5'b00010, 5'b00000, 1'b0, 1'b0, SINGLE_1, 4, 1, 1'b1, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no summary by time limit, expected run completion");
        $fatal(1, "watchdog expired");
    end

endmodule
